// File: rtl/arp_cache_table.sv
// Fully associative IPv4->MAC cache with per-entry aging, LRU-style replacement
// and a single-outstanding AXI-Lite-style query read channel.
module arp_cache_table #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMER_W = 32,
    parameter int unsigned AGE_W   = 16
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [TIMER_W-1:0]           cfg_tick_div,
    input  logic [AGE_W-1:0]             cfg_timeout,
    input  logic                         cfg_clear,
    input  logic                         upd_valid,
    output logic                         upd_ready,
    input  logic [31:0]                  upd_ip,
    input  logic [47:0]                  upd_mac,
    input  logic [31:0]                  query_araddr,
    input  logic                         query_arvalid,
    output logic                         query_arready,
    output logic [63:0]                  query_rdata,
    output logic                         query_rvalid,
    input  logic                         query_rready,
    output logic [$clog2(DEPTH+1)-1:0]   entry_count,
    output logic                         evict_pulse
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {
        Q_IDLE = 1'b0,
        Q_RESP = 1'b1
    } q_state_e;

    // Table storage
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [31:0]      ip_q  [DEPTH];
    logic [31:0]      ip_d  [DEPTH];
    logic [47:0]      mac_q [DEPTH];
    logic [47:0]      mac_d [DEPTH];
    logic [AGE_W-1:0] age_q [DEPTH];
    logic [AGE_W-1:0] age_d [DEPTH];

    logic [TIMER_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               evict_q, evict_d;

    q_state_e    q_state_q, q_state_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [63:0] rdata_q, rdata_d;

    logic             tick_c;
    logic             upd_write_c;
    logic             upd_hit_c;
    logic             free_found_c;
    logic [IDX_W-1:0] hit_idx_c;
    logic [IDX_W-1:0] free_idx_c;
    logic [IDX_W-1:0] victim_idx_c;
    logic [AGE_W-1:0] victim_age_c;
    logic [IDX_W-1:0] wr_idx_c;
    logic             q_hit_c;
    logic [47:0]      q_mac_c;

    assign upd_ready     = ~cfg_clear;
    assign query_arready = arready_q;
    assign query_rvalid  = rvalid_q;
    assign query_rdata   = rdata_q;
    assign entry_count   = count_q;
    assign evict_pulse   = evict_q;

    // Timebase: ticks when the counter reaches (or has overrun) the divider
    always_comb begin
        tick_c     = (tick_cnt_q >= cfg_tick_div);
        tick_cnt_d = tick_c ? '0 : tick_cnt_q + TIMER_W'(1);
    end

    // Update-side lookup: hit slot, lowest free slot, oldest valid slot
    always_comb begin
        upd_hit_c    = 1'b0;
        hit_idx_c    = '0;
        free_found_c = 1'b0;
        free_idx_c   = '0;
        victim_idx_c = '0;
        victim_age_c = age_q[0];
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (ip_q[i] == upd_ip) && !upd_hit_c) begin
                upd_hit_c = 1'b1;
                hit_idx_c = IDX_W'(i);
            end
            if (!valid_q[i] && !free_found_c) begin
                free_found_c = 1'b1;
                free_idx_c   = IDX_W'(i);
            end
            if (age_q[i] > victim_age_c) begin
                victim_age_c = age_q[i];
                victim_idx_c = IDX_W'(i);
            end
        end
        upd_write_c = upd_valid && !cfg_clear && (upd_ip != 32'h0) && (upd_ip != 32'hFFFF_FFFF);
        wr_idx_c    = upd_hit_c ? hit_idx_c : (free_found_c ? free_idx_c : victim_idx_c);
        evict_d     = upd_write_c && !upd_hit_c && !free_found_c;
    end

    // Next table state: aging/expiry, then update overrides, then clear overrides all
    always_comb begin
        valid_d = valid_q;
        ip_d    = ip_q;
        mac_d   = mac_q;
        age_d   = age_q;
        count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tick_c && valid_q[i]) begin
                age_d[i] = (age_q[i] == '1) ? age_q[i] : age_q[i] + AGE_W'(1);
                if ((cfg_timeout != '0) && (age_d[i] >= cfg_timeout)) begin
                    valid_d[i] = 1'b0;
                end
            end
            if (upd_write_c && (wr_idx_c == IDX_W'(i))) begin
                valid_d[i] = 1'b1;
                ip_d[i]    = upd_ip;
                mac_d[i]   = upd_mac;
                age_d[i]   = '0;
            end
            if (cfg_clear) begin
                valid_d[i] = 1'b0;
            end
            count_d = count_d + CNT_W'(valid_d[i]);
        end
    end

    // Query lookup against the registered table
    always_comb begin
        q_hit_c = 1'b0;
        q_mac_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (ip_q[i] == query_araddr)) begin
                q_hit_c = 1'b1;
                q_mac_c = q_mac_c | mac_q[i];
            end
        end
    end

    // Query FSM next state and registered channel outputs
    always_comb begin
        q_state_d = q_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        case (q_state_q)
            Q_IDLE: begin
                if (query_arvalid) begin
                    q_state_d = Q_RESP;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = {q_hit_c, 15'b0, q_mac_c};
                end
            end
            Q_RESP: begin
                if (query_rready) begin
                    q_state_d = Q_IDLE;
                    arready_d = 1'b1;
                    rvalid_d  = 1'b0;
                end
            end
            default: begin
                q_state_d = Q_IDLE;
                arready_d = 1'b1;
                rvalid_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            q_state_q  <= Q_IDLE;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            tick_cnt_q <= '0;
            valid_q    <= '0;
            count_q    <= '0;
            evict_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ip_q[i]  <= '0;
                mac_q[i] <= '0;
                age_q[i] <= '0;
            end
        end else begin
            q_state_q  <= q_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            tick_cnt_q <= tick_cnt_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
            evict_q    <= evict_d;
            ip_q       <= ip_d;
            mac_q      <= mac_d;
            age_q      <= age_d;
        end
    end

endmodule

// File: tb/tb_arp_cache_table.sv
// Bench for arp_cache_table: directed vector table, corner sequences and a
// randomized run checked every cycle against a behavioural cache model.
module tb_arp_cache_table;

    localparam int DEPTH   = 4;
    localparam int TIMER_W = 8;
    localparam int AGE_W   = 4;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int AGE_MAX = (1 << AGE_W) - 1;

    logic               aclk = 1'b0;
    logic               areset = 1'b1;
    logic [TIMER_W-1:0] cfg_tick_div = 8'd200;
    logic [AGE_W-1:0]   cfg_timeout = '0;
    logic               cfg_clear = 1'b0;
    logic               upd_valid = 1'b0;
    logic               upd_ready;
    logic [31:0]        upd_ip = '0;
    logic [47:0]        upd_mac = '0;
    logic [31:0]        query_araddr = '0;
    logic               query_arvalid = 1'b0;
    logic               query_arready;
    logic [63:0]        query_rdata;
    logic               query_rvalid;
    logic               query_rready = 1'b0;
    logic [CNT_W-1:0]   entry_count;
    logic               evict_pulse;

    arp_cache_table #(.DEPTH(DEPTH), .TIMER_W(TIMER_W), .AGE_W(AGE_W)) dut (
        .aclk(aclk), .areset(areset),
        .cfg_tick_div(cfg_tick_div), .cfg_timeout(cfg_timeout), .cfg_clear(cfg_clear),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_ip(upd_ip), .upd_mac(upd_mac),
        .query_araddr(query_araddr), .query_arvalid(query_arvalid), .query_arready(query_arready),
        .query_rdata(query_rdata), .query_rvalid(query_rvalid), .query_rready(query_rready),
        .entry_count(entry_count), .evict_pulse(evict_pulse)
    );

    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model of the cache contents and the query channel
    bit          m_valid [DEPTH];
    logic [31:0] m_ip    [DEPTH];
    logic [47:0] m_mac   [DEPTH];
    int          m_age   [DEPTH];
    int          m_tick;
    bit          m_busy;
    logic [63:0] m_rdata;
    bit          m_evict;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int find(input logic [31:0] ip);
        for (int i = 0; i < DEPTH; i++)
            if (m_valid[i] && m_ip[i] == ip) return i;
        return -1;
    endfunction

    function automatic int first_free();
        for (int i = 0; i < DEPTH; i++)
            if (!m_valid[i]) return i;
        return -1;
    endfunction

    function automatic int oldest();
        int best = 0;
        for (int i = 1; i < DEPTH; i++)
            if (m_age[i] > m_age[best]) best = i;
        return best;
    endfunction

    function automatic int popcount();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(m_valid[i]);
        return n;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven
    task automatic model_edge();
        int  slot;
        int  idx;
        bit  tick;
        if (areset) begin
            for (int i = 0; i < DEPTH; i++) begin m_valid[i] = 0; m_age[i] = 0; end
            m_tick = 0; m_busy = 0; m_rdata = '0; m_evict = 0;
            return;
        end
        if (!m_busy) begin
            if (query_arvalid) begin
                idx = find(query_araddr);
                m_rdata = (idx >= 0) ? {1'b1, 15'b0, m_mac[idx]} : 64'h0;
                m_busy = 1;
            end
        end else if (query_rready) begin
            m_busy = 0;
        end
        tick = (m_tick >= int'(cfg_tick_div));
        m_tick = tick ? 0 : m_tick + 1;
        slot = -1;
        m_evict = 0;
        if (upd_valid && !cfg_clear && upd_ip != 32'h0 && upd_ip != 32'hFFFF_FFFF) begin
            slot = find(upd_ip);
            if (slot < 0) slot = first_free();
            if (slot < 0) begin slot = oldest(); m_evict = 1; end
        end
        if (tick) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (m_valid[i]) begin
                    m_age[i] = (m_age[i] + 1 > AGE_MAX) ? AGE_MAX : m_age[i] + 1;
                    if (cfg_timeout != 0 && m_age[i] >= int'(cfg_timeout)) m_valid[i] = 0;
                end
            end
        end
        if (slot >= 0) begin
            m_valid[slot] = 1; m_ip[slot] = upd_ip; m_mac[slot] = upd_mac; m_age[slot] = 0;
        end
        if (cfg_clear)
            for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
    endtask

    // One clock: check combinational ready, clock, advance model, check registered outputs
    task automatic step();
        #1;
        check("upd_ready", 64'(upd_ready), 64'(!cfg_clear));
        @(posedge aclk);
        model_edge();
        #1;
        check("arready", 64'(query_arready), 64'(!m_busy));
        check("rvalid", 64'(query_rvalid), 64'(m_busy));
        check("entry_count", 64'(entry_count), 64'(popcount()));
        check("evict_pulse", 64'(evict_pulse), 64'(m_evict));
        if (m_busy) check("rdata", query_rdata, m_rdata);
    endtask

    task automatic do_update(input logic [31:0] ip, input logic [47:0] mac);
        upd_valid = 1'b1; upd_ip = ip; upd_mac = mac;
        step();
        upd_valid = 1'b0;
    endtask

    task automatic do_query(input logic [31:0] ip, output logic [63:0] rd);
        query_araddr = ip; query_arvalid = 1'b1;
        step();
        query_arvalid = 1'b0;
        check("query_latency_rvalid", 64'(query_rvalid), 64'h1);
        rd = query_rdata;
        query_rready = 1'b1;
        step();
        query_rready = 1'b0;
    endtask

    typedef struct {
        bit          is_upd;
        logic [31:0] ip;
        logic [47:0] mac;
        logic [63:0] exp_rdata;
        int          exp_count;
    } vec_t;

    localparam logic [31:0] IP_A = 32'h0A00_0001;

    initial begin
        vec_t        vecs[$];
        logic [63:0] rd;
        logic [63:0] rd0;
        logic [31:0] pool [7];

        vecs.push_back('{0, IP_A,         48'h0,            64'h0,                   0});
        vecs.push_back('{1, IP_A,         48'h0200_0000_0001, 64'h0,                 1});
        vecs.push_back('{0, IP_A,         48'h0,            64'h8000_0200_0000_0001, 1});
        vecs.push_back('{1, IP_A,         48'h0200_0000_000A, 64'h0,                 1});
        vecs.push_back('{0, IP_A,         48'h0,            64'h8000_0200_0000_000A, 1});
        vecs.push_back('{1, 32'h0,        48'h1111_2222_3333, 64'h0,                 1});
        vecs.push_back('{0, 32'h0,        48'h0,            64'h0,                   1});
        vecs.push_back('{1, 32'hFFFF_FFFF, 48'h4444_5555_6666, 64'h0,                1});
        vecs.push_back('{0, 32'hFFFF_FFFF, 48'h0,           64'h0,                   1});
        vecs.push_back('{1, 32'h0A00_0002, 48'h0200_0000_0002, 64'h0,                2});
        vecs.push_back('{0, 32'h0A00_0002, 48'h0,           64'h8000_0200_0000_0002, 2});

        step();
        step();
        areset = 1'b0;
        check("rst_arready", 64'(query_arready), 64'h1);
        check("rst_rvalid", 64'(query_rvalid), 64'h0);
        check("rst_rdata", query_rdata, 64'h0);
        check("rst_count", 64'(entry_count), 64'h0);
        check("rst_evict", 64'(evict_pulse), 64'h0);
        check("rst_upd_ready", 64'(upd_ready), 64'h1);

        foreach (vecs[k]) begin
            if (vecs[k].is_upd) begin
                do_update(vecs[k].ip, vecs[k].mac);
            end else begin
                do_query(vecs[k].ip, rd);
                check($sformatf("vec%0d_rdata", k), rd, vecs[k].exp_rdata);
            end
            check($sformatf("vec%0d_count", k), 64'(entry_count), 64'(vecs[k].exp_count));
        end

        // Update and query of the same new IP in one cycle: the query sees the old table
        upd_valid = 1'b1; upd_ip = 32'h0A00_0005; upd_mac = 48'h0200_0000_0005;
        query_arvalid = 1'b1; query_araddr = 32'h0A00_0005;
        step();
        upd_valid = 1'b0; query_arvalid = 1'b0;
        check("same_cycle_rvalid", 64'(query_rvalid), 64'h1);
        check("same_cycle_miss", query_rdata, 64'h0);
        query_rready = 1'b1;
        step();
        query_rready = 1'b0;
        do_query(32'h0A00_0005, rd);
        check("after_update_hit", rd, 64'h8000_0200_0000_0005);

        // Clear wins over a simultaneous update
        cfg_clear = 1'b1; upd_valid = 1'b1; upd_ip = 32'h0A00_0009; upd_mac = 48'h0200_0000_0009;
        #1;
        check("clear_upd_ready", 64'(upd_ready), 64'h0);
        step();
        cfg_clear = 1'b0; upd_valid = 1'b0;
        check("clear_count", 64'(entry_count), 64'h0);
        do_query(32'h0A00_0009, rd);
        check("clear_upd_dropped", rd, 64'h0);
        do_query(32'h0A00_0005, rd);
        check("clear_invalidates", rd, 64'h0);

        // Full table: the slot left unrefreshed longest is the one replaced
        cfg_tick_div = 8'd0;
        for (int k = 0; k < 4; k++) do_update(32'hC0A8_000A + k, 48'hAA00_0000_0000 + k);
        do_update(32'hC0A8_000A, 48'hAA00_0000_0000);
        do_update(32'hC0A8_000B, 48'hAA00_0000_0001);
        do_update(32'hC0A8_000D, 48'hAA00_0000_0003);
        check("full_count", 64'(entry_count), 64'h4);
        do_update(32'hC0A8_000E, 48'hBB00_0000_000E);
        check("evict_set", 64'(evict_pulse), 64'h1);
        check("evict_count", 64'(entry_count), 64'h4);
        step();
        check("evict_one_cycle", 64'(evict_pulse), 64'h0);
        do_query(32'hC0A8_000C, rd);
        check("victim_gone", rd, 64'h0);
        do_query(32'hC0A8_000E, rd);
        check("new_entry_hit", rd, 64'h8000_BB00_0000_000E);
        do_query(32'hC0A8_000A, rd);
        check("survivor_hit", rd, 64'h8000_AA00_0000_0000);

        // Back-pressured response stays stable; reset drops it
        query_araddr = 32'hC0A8_000E; query_arvalid = 1'b1;
        step();
        query_arvalid = 1'b0;
        rd0 = query_rdata;
        check("hold_first_rdata", rd0, 64'h8000_BB00_0000_000E);
        for (int k = 0; k < 5; k++) begin
            step();
            check("hold_rvalid", 64'(query_rvalid), 64'h1);
            check("hold_arready", 64'(query_arready), 64'h0);
            check("hold_rdata", query_rdata, rd0);
        end
        areset = 1'b1;
        step();
        check("reset_drops_rvalid", 64'(query_rvalid), 64'h0);

        // Expiry: divider 9, timeout 3, insert on first cycle after reset
        cfg_tick_div = 8'd9; cfg_timeout = 4'd3;
        step();
        areset = 1'b0;
        do_update(IP_A, 48'h0200_0000_0001);
        for (int k = 2; k < 30; k++) step();
        check("expiry_before", 64'(entry_count), 64'h1);
        step();
        check("expiry_at_cycle30", 64'(entry_count), 64'h0);

        // Randomized traffic against the model
        pool[0] = 32'h0; pool[1] = 32'hFFFF_FFFF;
        for (int k = 2; k < 7; k++) pool[k] = 32'h0A01_0000 + k;
        cfg_timeout = 4'd0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 99) == 0) cfg_tick_div = TIMER_W'($urandom_range(0, 4));
            if ($urandom_range(0, 99) == 0) cfg_timeout = AGE_W'($urandom_range(0, 12));
            areset        = ($urandom_range(0, 699) == 0);
            cfg_clear     = ($urandom_range(0, 79) == 0);
            upd_valid     = ($urandom_range(0, 2) == 0);
            upd_ip        = pool[$urandom_range(0, 6)];
            upd_mac       = {16'($urandom), $urandom};
            query_arvalid = ($urandom_range(0, 1) == 0);
            query_araddr  = pool[$urandom_range(0, 6)];
            query_rready  = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
